// File: rtl/kidx_dist_pkg.sv
// Shared definitions for the kernel-index distance array: FSM encoding and
// the default per-lane word width.
package kidx_dist_pkg;

  // Default width of one lane slice (index, kernel width and distance word)
  localparam int LANE_W = 8;

  // Controller states: waiting for a request, dividing, presenting a result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/kidx_dist_array_if.sv
// Request/response bundle for kidx_dist_array. The master side issues
// requests and consumes results; the slave side is the distance array.
interface kidx_dist_array_if import kidx_dist_pkg::*; #(
  parameter int WORD_WIDTH = LANE_W,
  parameter int NUM_LANES  = 4
) ();

  logic                            in_valid;
  logic                            in_ready;
  logic [WORD_WIDTH-1:0]           ke_width;
  logic [NUM_LANES*WORD_WIDTH-1:0] idx1;
  logic [NUM_LANES*WORD_WIDTH-1:0] idx2;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_LANES*WORD_WIDTH-1:0] vdist;
  logic [NUM_LANES*WORD_WIDTH-1:0] hdist;
  logic                            out_err;

  modport master (
    output in_valid, ke_width, idx1, idx2, out_ready,
    input  in_ready, out_valid, vdist, hdist, out_err
  );

  modport slave (
    input  in_valid, ke_width, idx1, idx2, out_ready,
    output in_ready, out_valid, vdist, hdist, out_err
  );

endinterface

// File: rtl/kidx_div_lane.sv
// One lane of the distance array: divides both indices by the kernel width
// with repeated subtraction and exposes the quotient/remainder differences.
// The done flag is registered, so it reports the state of the remainders as
// they stood one cycle earlier.
module kidx_div_lane import kidx_dist_pkg::*; #(
  parameter int WORD_WIDTH = LANE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] idx1_in,
  input  logic [WORD_WIDTH-1:0] idx2_in,
  output logic [WORD_WIDTH-1:0] vdist,
  output logic [WORD_WIDTH-1:0] hdist,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

  logic [WORD_WIDTH-1:0] rem1_q, rem1_d;
  logic [WORD_WIDTH-1:0] rem2_q, rem2_d;
  logic [WORD_WIDTH-1:0] quo1_q, quo1_d;
  logic [WORD_WIDTH-1:0] quo2_q, quo2_d;
  logic                  done_q, done_d;
  logic                  fw_zero;

  assign fw_zero = (fw == '0);

  // Load the indices on accept, then peel off one kernel width per cycle
  always_comb begin
    rem1_d = rem1_q;
    rem2_d = rem2_q;
    quo1_d = quo1_q;
    quo2_d = quo2_q;
    done_d = done_q;
    if (load) begin
      rem1_d = idx1_in;
      rem2_d = idx2_in;
      quo1_d = '0;
      quo2_d = '0;
      done_d = 1'b0;
    end else if (step) begin
      if (!fw_zero && (rem1_q >= fw)) begin
        rem1_d = rem1_q - fw;
        quo1_d = quo1_q + ONE;
      end
      if (!fw_zero && (rem2_q >= fw)) begin
        rem2_d = rem2_q - fw;
        quo2_d = quo2_q + ONE;
      end
      done_d = fw_zero || ((rem1_q < fw) && (rem2_q < fw));
    end
  end

  // Lane state registers, cleared asynchronously so an abort leaves nothing behind
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem1_q <= '0;
      rem2_q <= '0;
      quo1_q <= '0;
      quo2_q <= '0;
      done_q <= 1'b0;
    end else begin
      rem1_q <= rem1_d;
      rem2_q <= rem2_d;
      quo1_q <= quo1_d;
      quo2_q <= quo2_d;
      done_q <= done_d;
    end
  end

  assign vdist = quo2_q - quo1_q;
  assign hdist = rem2_q - rem1_q;
  assign done  = done_q;

endmodule

// File: rtl/kidx_dist_array.sv
// Kernel-index distance array: for each lane returns the row distance
// (idx2/FW - idx1/FW) and column distance (idx2%FW - idx1%FW) of two lowered
// indices. Owns the handshake FSM, the captured kernel width and the result
// registers; the per-lane division lives in kidx_div_lane.
module kidx_dist_array import kidx_dist_pkg::*; #(
  parameter int WORD_WIDTH = LANE_W,
  parameter int NUM_LANES  = 4
) (
  input logic               clk,
  input logic               reset_n,
  kidx_dist_array_if.slave  bus
);

  localparam int VEC_W = NUM_LANES * WORD_WIDTH;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] fw_q, fw_d;
  logic [VEC_W-1:0]      vdist_q, vdist_d;
  logic [VEC_W-1:0]      hdist_q, hdist_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  div_active;
  logic                  all_done;
  logic [VEC_W-1:0]      lane_v;
  logic [VEC_W-1:0]      lane_h;
  logic [NUM_LANES-1:0]  lane_done;

  assign accept     = bus.in_valid && (state_q == ST_IDLE);
  assign div_active = (state_q == ST_DIV);
  assign all_done   = &lane_done;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    kidx_div_lane #(.WORD_WIDTH(WORD_WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .step    (div_active),
      .fw      (fw_q),
      .idx1_in (bus.idx1[k*WORD_WIDTH +: WORD_WIDTH]),
      .idx2_in (bus.idx2[k*WORD_WIDTH +: WORD_WIDTH]),
      .vdist   (lane_v[k*WORD_WIDTH +: WORD_WIDTH]),
      .hdist   (lane_h[k*WORD_WIDTH +: WORD_WIDTH]),
      .done    (lane_done[k])
    );
  end

  // Sequence accept -> divide -> present; a zero kernel width yields a flagged zero result
  always_comb begin
    state_d = state_q;
    fw_d    = fw_q;
    vdist_d = vdist_q;
    hdist_d = hdist_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fw_d    = bus.ke_width;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (all_done) begin
          state_d = ST_OUT;
          if (fw_q == '0) begin
            vdist_d = '0;
            hdist_d = '0;
            err_d   = 1'b1;
          end else begin
            vdist_d = lane_v;
            hdist_d = lane_h;
            err_d   = 1'b0;
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fw_q    <= '0;
      vdist_q <= '0;
      hdist_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fw_q    <= fw_d;
      vdist_q <= vdist_d;
      hdist_q <= hdist_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.vdist     = vdist_q;
  assign bus.hdist     = hdist_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_kidx_dist_array.sv
// Testbench for kidx_dist_array: a scoreboard of expected results built from
// a divide/modulo reference model, checked as each result appears.
module tb_kidx_dist_array;

  localparam int W        = 8;
  localparam int L        = 4;
  localparam int DW       = W * L;
  localparam int MAX_WAIT = 400;

  typedef struct {
    logic [DW-1:0] v;
    logic [DW-1:0] h;
    logic          err;
    int            lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  exp_t sb_q[$];

  kidx_dist_array_if #(.WORD_WIDTH(W), .NUM_LANES(L)) bus_if ();

  kidx_dist_array #(.WORD_WIDTH(W), .NUM_LANES(L)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true division per lane, latency = largest quotient + 2
  function automatic exp_t model(input logic [W-1:0] fw, input logic [DW-1:0] i1,
                                 input logic [DW-1:0] i2);
    exp_t e;
    int maxq;
    logic [W-1:0] a, b, qa, qb, ra, rb;
    e.v = '0;
    e.h = '0;
    e.err = (fw == '0);
    maxq = 0;
    if (fw != '0) begin
      for (int k = 0; k < L; k++) begin
        a = i1[k*W +: W];
        b = i2[k*W +: W];
        qa = a / fw;
        qb = b / fw;
        ra = a % fw;
        rb = b % fw;
        e.v[k*W +: W] = qb - qa;
        e.h[k*W +: W] = rb - ra;
        if (int'(qa) > maxq) maxq = int'(qa);
        if (int'(qb) > maxq) maxq = int'(qb);
      end
    end
    e.lat = maxq + 2;
    return e;
  endfunction

  task automatic send_req(input logic [W-1:0] fw, input logic [DW-1:0] i1,
                          input logic [DW-1:0] i2);
    sb_q.push_back(model(fw, i1, i2));
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.ke_width = fw;
    bus_if.idx1     = i1;
    bus_if.idx2     = i2;
    for (int n = 0; n < 50 && !bus_if.in_ready; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.ke_width = W'($urandom);
    bus_if.idx1     = DW'($urandom);
    bus_if.idx2     = DW'($urandom);
  endtask

  task automatic wait_result(output bit seen, output int lat, output logic [DW-1:0] v,
                             output logic [DW-1:0] h, output logic err);
    seen = 1'b0;
    lat  = 0;
    v    = '0;
    h    = '0;
    err  = 1'b0;
    for (int e = 1; e <= MAX_WAIT; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.out_valid === 1'b1) begin
        seen = 1'b1;
        lat  = e;
        v    = bus_if.vdist;
        h    = bus_if.hdist;
        err  = bus_if.out_err;
        break;
      end
    end
  endtask

  task automatic ack_result();
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); end
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
    total++; if (bus_if.out_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_err got=%b exp=0", bus_if.out_err); end
    total++; if (bus_if.vdist !== '0) begin bad++; $display("[TB] FAIL reset_vdist got=%h exp=0", bus_if.vdist); end
    total++; if (bus_if.hdist !== '0) begin bad++; $display("[TB] FAIL reset_hdist got=%h exp=0", bus_if.hdist); end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0]  t_fw[5];
    logic [DW-1:0] t_i1[5];
    logic [DW-1:0] t_i2[5];
    bit seen; int lat; logic [DW-1:0] v, h; logic err; exp_t e;
    t_fw = '{8'd3, 8'd3, 8'd4, 8'd0, 8'd1};
    t_i1 = '{32'h0000_0001, 32'h0000_0005, {8'd15, 8'd9, 8'd4, 8'd0}, 32'hA1B2_C3D4, 32'h0000_0000};
    t_i2 = '{32'h0000_0007, 32'h0000_0003, {8'd3, 8'd2, 8'd8, 8'd1}, 32'h1122_3344, 32'h0000_00FF};
    for (int i = 0; i < 5; i++) begin
      send_req(t_fw[i], t_i1[i], t_i2[i]);
      wait_result(seen, lat, v, h, err);
      e = sb_q.pop_front();
      total++; if (!seen) begin bad++; $display("[TB] FAIL dir%0d_timeout got=no_out_valid exp=out_valid", i); end
      total++; if (lat !== e.lat) begin bad++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      total++; if (v !== e.v) begin bad++; $display("[TB] FAIL dir%0d_vdist got=%h exp=%h", i, v, e.v); end
      total++; if (h !== e.h) begin bad++; $display("[TB] FAIL dir%0d_hdist got=%h exp=%h", i, h, e.h); end
      total++; if (err !== e.err) begin bad++; $display("[TB] FAIL dir%0d_err got=%b exp=%b", i, err, e.err); end
      if (seen) ack_result();
    end
  endtask

  task automatic test_backpressure();
    bit seen; int lat; logic [DW-1:0] v, h; logic err; exp_t e;
    send_req(8'd3, 32'h0403_0201, 32'h0A0B_0C0D);
    wait_result(seen, lat, v, h, err);
    e = sb_q.pop_front();
    total++; if (!seen || v !== e.v || h !== e.h) begin bad++; $display("[TB] FAIL bp_result got=%b/%h/%h exp=1/%h/%h", seen, v, h, e.v, e.h); end
    for (int c = 0; c < 10; c++) begin
      bus_if.in_valid = 1'b1;
      bus_if.ke_width = W'($urandom);
      bus_if.idx1     = DW'($urandom);
      bus_if.idx2     = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.vdist !== e.v ||
          bus_if.hdist !== e.h || bus_if.out_err !== e.err) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d got=ov%b ir%b v%h h%h e%b exp=ov1 ir0 v%h h%h e%b", c,
                 bus_if.out_valid, bus_if.in_ready, bus_if.vdist, bus_if.hdist, bus_if.out_err,
                 e.v, e.h, e.err);
      end
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_out_valid got=%b exp=0", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready got=%b exp=1", bus_if.in_ready); end
    repeat (3) @(negedge clk);
    total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_accept got=ir%b ov%b exp=ir1 ov0", bus_if.in_ready, bus_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat; logic [DW-1:0] v, h; logic err; exp_t e;
    logic [W-1:0] fw;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fw = (i == 2) ? 8'd0 : W'($urandom_range(1, 12));
      send_req(fw, DW'($urandom), DW'($urandom));
      wait_result(seen, lat, v, h, err);
      e = sb_q.pop_front();
      total++; if (!seen || lat !== e.lat) begin bad++; $display("[TB] FAIL b2b%0d_latency got=%b/%0d exp=1/%0d", i, seen, lat, e.lat); end
      total++; if (v !== e.v || h !== e.h) begin bad++; $display("[TB] FAIL b2b%0d_dist got=%h/%h exp=%h/%h", i, v, h, e.v, e.h); end
      total++; if (err !== e.err) begin bad++; $display("[TB] FAIL b2b%0d_err got=%b exp=%b", i, err, e.err); end
    end
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen; int lat; logic [DW-1:0] v, h; logic err; exp_t e;
    int pulses;
    send_req(8'd1, 32'h0000_0000, 32'h0000_00C8);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) pulses++;
    end
    reset_n = 1'b0;
    #1;
    total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_in_reset got=ir%b ov%b exp=ir1 ov0", bus_if.in_ready, bus_if.out_valid); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    e = sb_q.pop_front();
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL abort_no_pulse got=%0d exp=0", pulses); end
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready got=%b exp=1", bus_if.in_ready); end
    send_req(8'd5, 32'h0C07_0302, 32'h1E00_2209);
    wait_result(seen, lat, v, h, err);
    e = sb_q.pop_front();
    total++; if (!seen || lat !== e.lat) begin bad++; $display("[TB] FAIL abort_fresh_latency got=%b/%0d exp=1/%0d", seen, lat, e.lat); end
    total++; if (v !== e.v || h !== e.h || err !== e.err) begin bad++; $display("[TB] FAIL abort_fresh_result got=%h/%h/%b exp=%h/%h/%b", v, h, err, e.v, e.h, e.err); end
    if (seen) ack_result();
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset_n          = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.ke_width  = '0;
    bus_if.idx1      = '0;
    bus_if.idx2      = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kidx_dist_array.md
KIDX_DIST_ARRAY -- requirements
Module: kidx_dist_array

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bitwidth of every index, kernel width and distance word.
REQ-002 Parameter NUM_LANES, default 4: number of independent (idx1, idx2) pairs processed per transaction.
REQ-003 clk  input  1  positive-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request carries valid ke_width, idx1, idx2.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 ke_width  input  WORD_WIDTH  kernel width FW, unsigned.
REQ-008 idx1  input  NUM_LANES*WORD_WIDTH  lowered index 1 per lane, unsigned; lane k at bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-009 idx2  input  NUM_LANES*WORD_WIDTH  lowered index 2 per lane, same packing.
REQ-010 out_valid  output  1  result words valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 vdist  output  NUM_LANES*WORD_WIDTH  per lane (idx2 / FW) - (idx1 / FW), two's complement.
REQ-013 hdist  output  NUM_LANES*WORD_WIDTH  per lane (idx2 % FW) - (idx1 % FW), two's complement.
REQ-014 out_err  output  1  result invalid because FW was 0.

Function
REQ-015 FSM states IDLE, DIV, OUT; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on a clk edge with in_valid && in_ready; ke_width, idx1 and idx2 are captured, quotient registers are cleared, remainder registers are loaded with the indices, and the FSM goes IDLE->DIV.
REQ-017 Inputs SHALL be ignored outside the accept edge; later input changes do not affect the transaction in flight.
REQ-018 In DIV, each cycle and for each lane and operand: if remainder >= FW, then remainder -= FW and quotient += 1; otherwise the operand holds.
REQ-019 DIV->OUT SHALL happen in the first DIV cycle where every remainder of every lane is < FW; in that cycle vdist and hdist are registered, both computed modulo 2^WORD_WIDTH.
REQ-020 Latency: with accept at edge 0, out_valid SHALL rise after edge max_q+2, where max_q is the largest quotient over all lanes and operands.
REQ-021 In OUT, out_valid SHALL be 1 and vdist, hdist and out_err SHALL hold stable until out_ready is 1 on a clk edge; that edge goes OUT->IDLE.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 If the captured FW==0, the FSM SHALL go DIV->OUT after exactly one DIV cycle, with vdist=hdist=0 and out_err=1; otherwise out_err=0.
REQ-024 No new request SHALL be accepted on the same edge as the OUT->IDLE handoff; in_ready rises the cycle after.
REQ-025 Operand width: idx >= FW arithmetic SHALL be unsigned, so idx=2^WORD_WIDTH-1 with FW=1 terminates after 2^WORD_WIDTH-1 subtractions.

Reset
REQ-026 While reset_n=0, the FSM SHALL be in IDLE and all outputs SHALL be: in_ready=1, out_valid=0, out_err=0, vdist=0, hdist=0; all internal registers are 0.
REQ-027 Reset asserted in DIV or OUT SHALL abort the transaction immediately with no out_valid pulse; after release the block SHALL be in IDLE.

Structure
REQ-028 Package kidx_dist_pkg SHALL hold the FSM state enum (2 bits) and the lane slice width constant.
REQ-029 One sub-module, kidx_div_lane, SHALL implement one lane's two remainder/quotient registers and the done flag; it is instantiated NUM_LANES times by generate.
REQ-030 The top level SHALL own the FSM, the handshake, the FW register and the AND-reduction of lane done flags.

Verification
REQ-031 NUM_LANES=1, FW=3, idx1=1, idx2=7, accept edge 0 -> vdist=8'h02, hdist=8'h00, out_valid after edge 4.
REQ-032 FW=3, idx1=5, idx2=3 -> vdist=8'h00, hdist=8'hFE, out_err=0.
REQ-033 Four lanes, FW=4, idx1={0,4,9,15}, idx2={1,8,2,3} -> each lane correct; out_valid after edge 5 (max_q=3).
REQ-034 Hold out_ready=0 for 10 cycles after out_valid, toggling in_valid=1 and indices -> outputs stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge.
REQ-035 FW=0, any indices -> out_valid after edge 2, out_err=1, vdist=hdist=0.
REQ-036 Assert reset_n=0 mid-DIV with FW=1, idx2=200 -> out_valid never pulses; after release, in_ready=1 and a fresh request completes correctly.
